// File: rtl/t08_mmio_arbiter_pkg.sv
// Shared types and constants for the two-requester MMIO arbiter.
package t08_mmio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/t08_mmio_arbiter_if.sv
// MMIO command/response bus. master = arbiter side, slave = MMIO target side.
interface t08_mmio_arbiter_if;
  logic        mmio_read_o;
  logic        mmio_write_o;
  logic [31:0] mmio_addr_o;
  logic [31:0] mmio_wdata_o;
  logic [31:0] mmio_rdata_i;
  logic        mmio_busy_i;
  logic        mmio_done_i;

  modport master (
    output mmio_read_o, mmio_write_o, mmio_addr_o, mmio_wdata_o,
    input  mmio_rdata_i, mmio_busy_i, mmio_done_i
  );

  modport slave (
    input  mmio_read_o, mmio_write_o, mmio_addr_o, mmio_wdata_o,
    output mmio_rdata_i, mmio_busy_i, mmio_done_i
  );
endinterface

// File: rtl/t08_arb_timeout.sv
// Saturating WAIT-cycle counter; expired_o flags that TIMEOUT cycles have elapsed.
module t08_arb_timeout #(
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment; increment stops at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/t08_mmio_arbiter.sv
// Arbitrates the single MMIO port between fetch (F) and data (D) requesters.
// D has priority; F is forced after STARVE_LIMIT consecutive D grants while F waits.
module t08_mmio_arbiter
  import t08_mmio_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] ERR_WORD     = ERR_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  input  logic        d_req_i,
  input  logic        d_write_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        f_done_o,
  output logic        d_done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  t08_mmio_arbiter_if.master mmio
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          issue_s;
  logic          tmo_clr_s, tmo_load_s, tmo_en_s, tmo_expired_s;

  t08_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tmo_clr_s),
    .load_i     (tmo_load_s),
    .load_val_i ({TW{1'b0}}),
    .en_i       (tmo_en_s),
    .expired_o  (tmo_expired_s)
  );

  // Next-state, request latching, starvation tracking and response capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    starve_d   = starve_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    issue_s    = 1'b0;
    tmo_clr_s  = 1'b0;
    tmo_load_s = 1'b0;
    tmo_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req_i && (!d_req_i || (starve_q == SW'(STARVE_LIMIT)))) begin
          owner_d  = OWN_F;
          addr_d   = f_addr_i;
          write_d  = 1'b0;
          wdata_d  = 32'd0;
          starve_d = {SW{1'b0}};
          state_d  = ISSUE;
        end else if (d_req_i) begin
          owner_d = OWN_D;
          addr_d  = d_addr_i;
          write_d = d_write_i;
          wdata_d = d_wdata_i;
          if (f_req_i && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
          end else if (f_req_i) begin
            starve_d = starve_q;
          end else begin
            starve_d = {SW{1'b0}};
          end
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!mmio.mmio_busy_i) begin
          issue_s    = 1'b1;
          tmo_load_s = 1'b1;
          state_d    = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        tmo_en_s = 1'b1;
        if (mmio.mmio_done_i) begin
          rdata_d = write_q ? 32'd0 : mmio.mmio_rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_expired_s) begin
          rdata_d = write_q ? 32'd0 : ERR_WORD;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        tmo_clr_s = 1'b1;
        rdata_d   = 32'd0;
        err_d     = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_F;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      write_q  <= 1'b0;
      starve_q <= {SW{1'b0}};
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode from registered state, so reset clears them immediately.
  assign busy_o            = (state_q != IDLE);
  assign f_done_o          = (state_q == RESP) && (owner_q == OWN_F);
  assign d_done_o          = (state_q == RESP) && (owner_q == OWN_D);
  assign rdata_o           = rdata_q;
  assign err_o             = err_q;
  assign mmio.mmio_read_o  = issue_s && !write_q;
  assign mmio.mmio_write_o = issue_s && write_q;
  assign mmio.mmio_addr_o  = ((state_q == ISSUE) || (state_q == WAIT)) ? addr_q : 32'd0;
  assign mmio.mmio_wdata_o = ((state_q == ISSUE) || (state_q == WAIT)) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_t08_mmio_arbiter.sv
// Directed bench for t08_mmio_arbiter with a small MMIO responder model.
module tb_t08_mmio_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req_i = 1'b0;
  logic [31:0] f_addr_i = 32'd0;
  logic        d_req_i = 1'b0;
  logic        d_write_i = 1'b0;
  logic [31:0] d_addr_i = 32'd0;
  logic [31:0] d_wdata_i = 32'd0;
  logic        f_done_o, d_done_o, err_o, busy_o;
  logic [31:0] rdata_o;

  t08_mmio_arbiter_if mmio_bus ();

  t08_mmio_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8), .ERR_WORD(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i),
    .d_req_i(d_req_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .f_done_o(f_done_o), .d_done_o(d_done_o), .rdata_o(rdata_o), .err_o(err_o),
    .busy_o(busy_o), .mmio(mmio_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // MMIO model controls: rsp_lat = cycles from issue to done (0 = never), rsp_data = read word.
  int          rsp_lat = 1;
  logic [31:0] rsp_data = 32'd0;
  int          pend = 0;

  // Observations collected by the monitor.
  int          issue_cnt = 0;
  logic [31:0] issue_log [0:63];
  logic [31:0] last_addr = 32'd0, last_wdata = 32'd0;
  logic        last_write = 1'b0;
  int          issue_cyc = 0;
  int          f_done_cnt = 0, d_done_cnt = 0;
  logic        done_owner_d = 1'b0;
  logic [31:0] done_rdata = 32'd0;
  logic        done_err = 1'b0;
  int          done_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = f_done_cnt + d_done_cnt;
    int n = 0;
    while (((f_done_cnt + d_done_cnt) == start) && (n < budget)) begin
      step();
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'((f_done_cnt + d_done_cnt) != start), 32'd1);
  endtask

  task automatic wait_issue(input string tag, input int target, input int budget);
    int n = 0;
    while ((issue_cnt < target) && (n < budget)) begin
      step();
      n++;
    end
    check_eq({tag, "_issue_seen"}, 32'(issue_cnt >= target), 32'd1);
  endtask

  always @(posedge clk) cyc++;

  // MMIO responder: drives done/rdata for one cycle rsp_lat cycles after issue.
  always @(posedge clk) begin
    #1;
    mmio_bus.mmio_done_i = 1'b0;
    mmio_bus.mmio_rdata_i = 32'd0;
    if (rst) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mmio_bus.mmio_done_i = 1'b1;
        mmio_bus.mmio_rdata_i = rsp_data;
      end
    end
  end

  // Monitor: samples on the falling edge, records issues and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (mmio_bus.mmio_read_o || mmio_bus.mmio_write_o) begin
        if (issue_cnt < 64) issue_log[issue_cnt] = mmio_bus.mmio_addr_o;
        issue_cnt++;
        last_addr = mmio_bus.mmio_addr_o;
        last_wdata = mmio_bus.mmio_wdata_o;
        last_write = mmio_bus.mmio_write_o;
        issue_cyc = cyc;
        pend = rsp_lat;
      end
      if (f_done_o || d_done_o) begin
        if (f_done_o) f_done_cnt++;
        if (d_done_o) d_done_cnt++;
        done_owner_d = d_done_o;
        done_rdata = rdata_o;
        done_err = err_o;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    int s_issue, s_fd, s_dd;
    mmio_bus.mmio_busy_i = 1'b0;
    mmio_bus.mmio_done_i = 1'b0;
    mmio_bus.mmio_rdata_i = 32'd0;
    #1;
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'({f_done_o, d_done_o}), 32'd0);
    check_eq("rst_strobes", 32'({mmio_bus.mmio_read_o, mmio_bus.mmio_write_o}), 32'd0);
    check_eq("rst_addr", mmio_bus.mmio_addr_o, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Single D read, done 2 cycles after issue.
    s_issue = issue_cnt;
    rsp_lat = 2; rsp_data = 32'h1234_5678;
    d_addr_i = 32'h10; d_write_i = 1'b0; d_req_i = 1'b1;
    wait_done("rd", 20);
    d_req_i = 1'b0;
    check_eq("rd_issues", 32'(issue_cnt - s_issue), 32'd1);
    check_eq("rd_addr", last_addr, 32'h10);
    check_eq("rd_is_read", 32'(last_write), 32'd0);
    check_eq("rd_owner_d", 32'(done_owner_d), 32'd1);
    check_eq("rd_rdata", done_rdata, 32'h1234_5678);
    check_eq("rd_err", 32'(done_err), 32'd0);
    check_eq("rd_latency", 32'(done_cyc - issue_cyc), 32'd3);
    check_eq("rd_rdata_after", rdata_o, 32'd0);
    check_eq("rd_idle_busy", 32'(busy_o), 32'd0);
    step();

    // Both requesters held: D x4, then F, then D.
    s_issue = issue_cnt; s_fd = f_done_cnt; s_dd = d_done_cnt;
    rsp_lat = 1; rsp_data = 32'h0000_0001;
    f_addr_i = 32'h40; f_req_i = 1'b1;
    d_addr_i = 32'h80; d_write_i = 1'b0; d_req_i = 1'b1;
    wait_issue("arb", s_issue + 6, 100);
    f_req_i = 1'b0; d_req_i = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check_eq("arb_issue_count", 32'(issue_cnt - s_issue), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("arb_grant%0d", k), issue_log[s_issue + k], (k == 4) ? 32'h40 : 32'h80);
    end
    check_eq("arb_f_dones", 32'(f_done_cnt - s_fd), 32'd1);
    check_eq("arb_d_dones", 32'(d_done_cnt - s_dd), 32'd5);

    // D write held in ISSUE by mmio_busy_i for 3 cycles.
    s_issue = issue_cnt;
    rsp_lat = 1; rsp_data = 32'h1111_1111;
    mmio_bus.mmio_busy_i = 1'b1;
    d_addr_i = 32'h20; d_wdata_i = 32'hCAFE_F00D; d_write_i = 1'b1; d_req_i = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("wr_hold_strobe%0d", k), 32'(mmio_bus.mmio_write_o), 32'd0);
      check_eq($sformatf("wr_hold_busy%0d", k), 32'(busy_o), 32'd1);
      step();
    end
    check_eq("wr_no_issue_yet", 32'(issue_cnt - s_issue), 32'd0);
    mmio_bus.mmio_busy_i = 1'b0;
    wait_done("wr", 20);
    d_req_i = 1'b0; d_write_i = 1'b0;
    check_eq("wr_issues", 32'(issue_cnt - s_issue), 32'd1);
    check_eq("wr_is_write", 32'(last_write), 32'd1);
    check_eq("wr_addr", last_addr, 32'h20);
    check_eq("wr_wdata", last_wdata, 32'hCAFE_F00D);
    check_eq("wr_rdata", done_rdata, 32'd0);
    check_eq("wr_err", 32'(done_err), 32'd0);
    step();

    // F read with no MMIO response: timeout after 8 counted WAIT cycles.
    rsp_lat = 0;
    f_addr_i = 32'h44; f_req_i = 1'b1;
    wait_done("tmo", 40);
    f_req_i = 1'b0;
    check_eq("tmo_owner_f", 32'(done_owner_d), 32'd0);
    check_eq("tmo_rdata", done_rdata, 32'hDEAD_BEEF);
    check_eq("tmo_err", 32'(done_err), 32'd1);
    check_eq("tmo_latency", 32'(done_cyc - issue_cyc), 32'd10);
    check_eq("tmo_idle", 32'(busy_o), 32'd0);
    rsp_lat = 1; rsp_data = 32'h0BAD_F00D;
    d_addr_i = 32'h14; d_req_i = 1'b1;
    wait_done("post_tmo", 20);
    d_req_i = 1'b0;
    check_eq("post_tmo_rdata", done_rdata, 32'h0BAD_F00D);
    check_eq("post_tmo_err", 32'(done_err), 32'd0);
    step();

    // Reset asserted while waiting in WAIT.
    s_issue = issue_cnt;
    rsp_lat = 0;
    d_addr_i = 32'h30; d_req_i = 1'b1;
    wait_issue("rst", s_issue + 1, 20);
    step(); step();
    check_eq("rst_pre_busy", 32'(busy_o), 32'd1);
    check_eq("rst_pre_addr", mmio_bus.mmio_addr_o, 32'h30);
    #2;
    rst = 1'b1; d_req_i = 1'b0;
    #1;
    check_eq("rst_mid_busy", 32'(busy_o), 32'd0);
    check_eq("rst_mid_addr", mmio_bus.mmio_addr_o, 32'd0);
    s_fd = f_done_cnt; s_dd = d_done_cnt;
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) step();
    check_eq("rst_no_done", 32'((f_done_cnt - s_fd) + (d_done_cnt - s_dd)), 32'd0);
    rsp_lat = 1; rsp_data = 32'hA5A5_5A5A;
    d_addr_i = 32'h34; d_req_i = 1'b1;
    wait_done("post_rst", 20);
    d_req_i = 1'b0;
    check_eq("post_rst_rdata", done_rdata, 32'hA5A5_5A5A);
    check_eq("post_rst_addr", last_addr, 32'h34);
    step();

    // D drops its request the cycle after grant.
    s_issue = issue_cnt; s_dd = d_done_cnt;
    rsp_lat = 1; rsp_data = 32'h600D_CAFE;
    d_addr_i = 32'h50; d_req_i = 1'b1;
    step();
    d_req_i = 1'b0;
    wait_done("drop", 20);
    for (int k = 0; k < 5; k++) step();
    check_eq("drop_issues", 32'(issue_cnt - s_issue), 32'd1);
    check_eq("drop_addr", last_addr, 32'h50);
    check_eq("drop_d_done", 32'(d_done_cnt - s_dd), 32'd1);
    check_eq("drop_rdata", done_rdata, 32'h600D_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
